room_thermal_model: RTL and testbench

//  Closed-loop plant model on the far side of the aircon controller: consumes

---
 rtl/room_thermal_model.sv | 140 ++++++++++++++
 tb/tb_room_thermal_model.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/room_thermal_model.sv
// Room thermal plant: temperature steps once per prescaled tick (heat/cool/drift to ambient), 1-cycle update latency.
// Optional DISTURB_EN adds an LFSR-driven +1 disturbance on idle ticks; ports are identical in both builds.
module room_thermal_model #(
  parameter int TICK_DIV   = 16,
  parameter int INIT_TEMP  = 18,
  parameter int HEAT_STEP  = 1,
  parameter int COOL_STEP  = 1,
  parameter int LEAK_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       heating,
  input  logic       cooling,
  input  logic [4:0] ambient,
  output logic [4:0] temperature,
  output logic       tick,
  output logic [1:0] mode,
  output logic       fault
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int LW = (LEAK_TICKS > 1) ? $clog2(LEAK_TICKS) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [LW-1:0] leak_q, leak_d;
  logic [4:0]    temp_q, temp_d;
  logic          tick_q, tick_d;
  logic [1:0]    mode_q, mode_d;
  logic          fault_q, fault_d;

  logic          update;
  logic [5:0]    sum6, diff6;
  logic [4:0]    heat_t, cool_t, drift_t, idle_t;

`ifdef DISTURB_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic       lfsr_fb;
`endif

  // Saturating arithmetic done one bit wider; bit 5 flags overflow/borrow.
  always_comb begin
    sum6    = {1'b0, temp_q} + 6'(HEAT_STEP);
    diff6   = {1'b0, temp_q} - 6'(COOL_STEP);
    heat_t  = sum6[5]  ? 5'd31 : sum6[4:0];
    cool_t  = diff6[5] ? 5'd0  : diff6[4:0];
    if (temp_q < ambient) begin
      drift_t = temp_q + 5'd1;
    end else if (temp_q > ambient) begin
      drift_t = temp_q - 5'd1;
    end else begin
      drift_t = temp_q;
    end
  end

  always_comb begin
    update  = enable && (presc_q == PW'(TICK_DIV - 1));
    presc_d = presc_q;
    leak_d  = leak_q;
    temp_d  = temp_q;
    mode_d  = mode_q;
    fault_d = fault_q;
    tick_d  = update;
    idle_t  = temp_q;

    if (enable) begin
      presc_d = update ? '0 : presc_q + 1'b1;
    end

    if (update) begin
      if (heating && cooling) begin
        fault_d = 1'b1;
        mode_d  = 2'b11;
        leak_d  = '0;
      end else if (heating) begin
        temp_d  = heat_t;
        mode_d  = 2'b01;
        leak_d  = '0;
      end else if (cooling) begin
        temp_d  = cool_t;
        mode_d  = 2'b10;
        leak_d  = '0;
      end else begin
        mode_d = 2'b00;
        if (leak_q == LW'(LEAK_TICKS - 1)) begin
          leak_d = '0;
          idle_t = drift_t;
        end else begin
          leak_d = leak_q + 1'b1;
        end
        temp_d = idle_t;
`ifdef DISTURB_EN
        if (lfsr_q[1:0] == 2'b11) begin
          temp_d = (idle_t == 5'd31) ? 5'd31 : idle_t + 5'd1;
        end
`endif
      end
    end
  end

`ifdef DISTURB_EN
  // Fibonacci taps for x^8+x^6+x^5+x^4+1
  always_comb begin
    lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    lfsr_d  = update ? {lfsr_q[6:0], lfsr_fb} : lfsr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      leak_q  <= '0;
      temp_q  <= 5'(INIT_TEMP);
      tick_q  <= 1'b0;
      mode_q  <= 2'b00;
      fault_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      leak_q  <= leak_d;
      temp_q  <= temp_d;
      tick_q  <= tick_d;
      mode_q  <= mode_d;
      fault_q <= fault_d;
    end
  end

  assign temperature = temp_q;
  assign tick        = tick_q;
  assign mode        = mode_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_room_thermal_model.sv
// Directed bench for room_thermal_model with TICK_DIV=4, LEAK_TICKS=2, INIT_TEMP=18, unit steps.
module tb_room_thermal_model;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       heating;
  logic       cooling;
  logic [4:0] ambient;
  logic [4:0] temperature;
  logic       tick;
  logic [1:0] mode;
  logic       fault;

  int n_checks = 0;
  int n_fails  = 0;
  int exp_t;
  int tick_cnt;

  room_thermal_model #(
    .TICK_DIV(4), .INIT_TEMP(18), .HEAT_STEP(1), .COOL_STEP(1), .LEAK_TICKS(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .heating(heating), .cooling(cooling),
    .ambient(ambient), .temperature(temperature), .tick(tick), .mode(mode), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; heating = 1'b0; cooling = 1'b0; ambient = 5'd15;

    // 1. reset
    for (int i = 0; i < 3; i++) cyc();
    rst = 1'b0;
    check("rst_temp", temperature, 18);
    check("rst_tick", tick, 0);
    check("rst_mode", mode, 0);
    check("rst_fault", fault, 0);

    // 2. heating 40 cycles: tick on every 4th, +1 per tick
    heating = 1'b1;
    exp_t = 18;
    tick_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (i % 4 == 3) exp_t++;
      if (tick) tick_cnt++;
      check("heat_tick", tick, (i % 4 == 3) ? 1 : 0);
      check("heat_temp", temperature, exp_t);
    end
    check("heat_tick_cnt", tick_cnt, 10);
    check("heat_temp_28", temperature, 28);
    check("heat_mode", mode, 1);

    // 3. keep heating 20 ticks: saturates at 31
    for (int i = 0; i < 80; i++) begin
      cyc();
      if (i % 4 == 3) begin
        exp_t = (exp_t == 31) ? 31 : exp_t + 1;
        check("sat_temp", temperature, exp_t);
      end
    end
    check("sat_temp_31", temperature, 31);

    // 4. cool 11 ticks to 20, then idle drift to ambient 15
    heating = 1'b0; cooling = 1'b1;
    for (int i = 0; i < 44; i++) cyc();
    check("cool_temp_20", temperature, 20);
    check("cool_mode", mode, 2);
    cooling = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      for (int i = 0; i < 8; i++) cyc();
      check("drift_temp", temperature, 20 - k);
    end
    check("drift_mode", mode, 0);
    for (int i = 0; i < 16; i++) cyc();
    check("drift_hold_15", temperature, 15);

    // 5. conflict tick, then cooling with sticky fault
    heating = 1'b1; cooling = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    check("conf_fault", fault, 1);
    check("conf_mode", mode, 3);
    check("conf_temp", temperature, 15);
    heating = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    check("postconf_temp", temperature, 14);
    check("postconf_mode", mode, 2);
    check("postconf_fault", fault, 1);

    // heating pulse between update edges is ignored
    cooling = 1'b0; heating = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    heating = 1'b0;
    cyc();
    check("glitch_tick", tick, 1);
    check("glitch_temp", temperature, 14);
    check("glitch_mode", mode, 0);

    // 6. freeze mid-count, then reset at prescaler=2
    cyc();
    enable = 1'b0;
    tick_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (tick) tick_cnt++;
    end
    check("frozen_ticks", tick_cnt, 0);
    check("frozen_temp", temperature, 14);
    enable = 1'b1;
    cyc();
    rst = 1'b1;
    cyc();
    check("rst2_tick", tick, 0);
    check("rst2_temp", temperature, 18);
    rst = 1'b0;
    check("rst2_fault", fault, 0);
    check("rst2_mode", mode, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check("rst2_first_tick", tick, (i == 4) ? 1 : 0);
    end
    check("rst2_tick_temp", temperature, 18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
